shift_unit_seq: RTL and testbench

Parametrised multi-cycle shift unit that performs SLL, SRL, SRA and ROR on a WIDTH-bit operand, with the shift amount taken from the instruction shamt field or from a register for the variable forms. It shifts STEP bit positions per cycle under a start/busy/done handshake. It sits beside the single-cycle ALU in the MIPS datapath and serves the shift instructions, so the ALU no longer needs a full barrel shifter. The controller stalls the PC while busy is high.

---
 rtl/shift_pkg.sv | 57 +++++
 rtl/shift_step.sv | 43 ++++
 rtl/shift_unit_seq.sv | 116 +++++++++++
 tb/tb_shift_unit_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift unit and the ALU decoder.
// Holds the shift operation encodings, the shift unit state encodings and
// the MIPS funct codes that select a shift.
// No ports; imported with "import shift_pkg::*".
package shift_pkg;

    // Shift operation as seen on the i_op port of shift_unit_seq.
    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } shift_op_e;

    // Controller states of shift_unit_seq.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } shift_state_e;

    // R-type funct codes that aludec routes to the shift unit.
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;

    // Result of decoding a funct field: whether it is a shift at all,
    // whether the amount comes from rs (variable form) or from shamt,
    // and which shift operation to request.
    typedef struct packed {
        logic      valid;
        logic      variable;
        shift_op_e op;
    } shift_decode_t;

    // Maps a funct code to the shift request the controller should issue.
    function automatic shift_decode_t decodeFunct(input logic [5:0] funct);
        shift_decode_t d;
        d.valid    = 1'b1;
        d.variable = 1'b0;
        d.op       = SH_SLL;
        case (funct)
            FN_SLL:  d.op = SH_SLL;
            FN_SRL:  d.op = SH_SRL;
            FN_SRA:  d.op = SH_SRA;
            FN_SLLV: begin d.op = SH_SLL; d.variable = 1'b1; end
            FN_SRLV: begin d.op = SH_SRL; d.variable = 1'b1; end
            FN_SRAV: begin d.op = SH_SRA; d.variable = 1'b1; end
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One step of the sequential shifter: shifts a value by k positions,
// where 0 <= k <= STEP, in a purely combinational way.
// Ports:
//   i_value  value to shift
//   i_op     shift operation (SLL/SRL/SRA/ROR)
//   i_k      number of positions for this step
//   i_fill   fill bit used by SRA (the operand sign captured at accept)
//   o_value  shifted value
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] i_value,
    input  shift_op_e        i_op,
    input  logic [KW-1:0]    i_k,
    input  logic             i_fill,
    output logic [WIDTH-1:0] o_value
);

    localparam int RW = $clog2(WIDTH + 1);

    // Left-shift amount for the wrap-around half of a rotate. For k=0 this
    // equals WIDTH, which shifts everything out and leaves the value intact.
    logic [RW-1:0] w_lAmt;
    assign w_lAmt = RW'(WIDTH) - RW'(i_k);

    // SRA with a one fill is done by inverting, zero-filling and inverting
    // back, so the fill comes from the saved sign rather than the current MSB.
    always_comb begin
        o_value = i_value;
        case (i_op)
            SH_SLL:  o_value = i_value << i_k;
            SH_SRL:  o_value = i_value >> i_k;
            SH_SRA:  o_value = i_fill ? ~((~i_value) >> i_k) : (i_value >> i_k);
            SH_ROR:  o_value = (i_value >> i_k) | (i_value << w_lAmt);
            default: o_value = i_value;
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift unit for the MIPS datapath. Shifts a WIDTH-bit operand
// by up to STEP positions per cycle under a start/busy/done handshake.
// Ports:
//   clk        clock
//   reset      asynchronous active-high reset, aborts any operation
//   i_start    request, accepted in IDLE or DONE
//   i_op       00 SLL, 01 SRL, 10 SRA, 11 ROR
//   i_data_in  operand
//   i_shamt    shift amount
//   o_busy     high while shifting
//   o_done     one-cycle pulse, o_result valid
//   o_result   shift register contents, held until the next accept
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic [SHW-1:0]   i_shamt,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int KW = $clog2(STEP + 1);

    shift_state_e     r_state;
    shift_state_e     w_nextState;
    logic [WIDTH-1:0] r_sreg;
    logic [SHW-1:0]   r_cnt;
    shift_op_e        r_opr;
    logic             r_fill;

    logic             w_accept;
    logic [KW-1:0]    w_k;
    logic [SHW-1:0]   w_cntNext;
    logic [WIDTH-1:0] w_stepped;

    // A new request is taken in IDLE and also in DONE, which gives
    // back-to-back operation without an idle bubble.
    assign w_accept = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Positions shifted this cycle: the remaining count, capped at STEP.
    assign w_k       = (32'(r_cnt) < STEP) ? KW'(r_cnt) : KW'(STEP);
    assign w_cntNext = r_cnt - SHW'(w_k);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .i_value (r_sreg),
        .i_op    (r_opr),
        .i_k     (w_k),
        .i_fill  (r_fill),
        .o_value (w_stepped)
    );

    // State register; reset aborts immediately without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A zero shift amount goes straight to DONE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_nextState = (i_shamt == '0) ? S_DONE : S_SHIFT;
                end else begin
                    w_nextState = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (w_cntNext == '0) begin
                    w_nextState = S_DONE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Operand, count and operation registers. The operand sign is latched
    // at accept so SRA keeps filling with it across every step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_opr  <= SH_SLL;
            r_fill <= 1'b0;
        end else if (w_accept) begin
            r_sreg <= i_data_in;
            r_cnt  <= i_shamt;
            r_opr  <= shift_op_e'(i_op);
            r_fill <= i_data_in[WIDTH-1];
        end else if (r_state == S_SHIFT) begin
            r_sreg <= w_stepped;
            r_cnt  <= w_cntNext;
        end
    end

    assign o_busy   = (r_state == S_SHIFT);
    assign o_done   = (r_state == S_DONE);
    assign o_result = r_sreg;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Testbench for shift_unit_seq. Five instances with STEP = 1, 2, 4, 8, 32
// share the operand inputs and have individual start lines, so a single
// request can be run on all of them and compared against a reference model.
module tb_shift_unit_seq;
    import shift_pkg::*;

    localparam int NDUT = 5;

    logic        clk;
    logic        reset;
    logic [4:0]  start;
    logic [1:0]  op;
    logic [31:0] dataIn;
    logic [4:0]  shamt;
    logic [4:0]  busy;
    logic [4:0]  done;
    logic [31:0] result [NDUT];

    int          compareCnt;
    int          failCnt;
    int          lat [NDUT];
    int          busyCycles [NDUT];
    logic [31:0] res [NDUT];

    // Generate the five instances with STEP = 1, 2, 4, 8 and 32.
    for (genvar g = 0; g < NDUT; g++) begin : gDut
        shift_unit_seq #(
            .WIDTH (32),
            .STEP  ((g == 4) ? 32 : (1 << g))
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .i_start   (start[g]),
            .i_op      (op),
            .i_data_in (dataIn),
            .i_shamt   (shamt),
            .o_busy    (busy[g]),
            .o_done    (done[g]),
            .o_result  (result[g])
        );
    end

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int stepOf(input int idx);
        return (idx == 4) ? 32 : (1 << idx);
    endfunction

    // Reference shift written directly from the operation definitions.
    function automatic logic [31:0] refShift(input logic [1:0] o, input logic [31:0] d, input int n);
        logic [31:0] r;
        case (o)
            SH_SLL:  r = d << n;
            SH_SRL:  r = d >> n;
            SH_SRA:  r = 32'($signed(d) >>> n);
            default: r = (n == 0) ? d : ((d >> n) | (d << (32 - n)));
        endcase
        return r;
    endfunction

    // Cycles from accept to the done pulse: one per STEP chunk plus DONE.
    function automatic int refLatency(input int n, input int s);
        return (n + s - 1) / s + 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCnt++;
        assert (observed === expected) else begin
            failCnt++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Issues one request to every instance in mask, follows each one to its
    // done pulse and checks result, latency and number of busy cycles.
    task automatic applyStimulus(input logic [4:0] mask, input logic [1:0] o, input logic [31:0] d, input logic [4:0] n);
        logic allDone;
        @(negedge clk);
        op     = o;
        dataIn = d;
        shamt  = n;
        start  = mask;
        for (int i = 0; i < NDUT; i++) begin
            lat[i]        = 0;
            busyCycles[i] = 0;
            res[i]        = 'x;
        end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start   = '0;
            allDone = 1'b1;
            for (int i = 0; i < NDUT; i++) begin
                if (mask[i] && lat[i] == 0) begin
                    if (busy[i]) busyCycles[i]++;
                    if (done[i]) begin
                        lat[i] = c;
                        res[i] = result[i];
                    end
                end
                if (mask[i] && lat[i] == 0) allDone = 1'b0;
            end
            if (allDone) break;
        end
        for (int i = 0; i < NDUT; i++) begin
            if (mask[i]) begin
                checkOutput($sformatf("result s%0d op%0d n%0d", stepOf(i), o, n), res[i], refShift(o, d, int'(n)));
                checkOutput($sformatf("latency s%0d op%0d n%0d", stepOf(i), o, n), lat[i], refLatency(int'(n), stepOf(i)));
                checkOutput($sformatf("busycnt s%0d op%0d n%0d", stepOf(i), o, n), busyCycles[i], refLatency(int'(n), stepOf(i)) - 1);
            end
        end
    endtask

    // Steps whole cycles until instance idx shows done, with a cycle budget.
    task automatic waitDone(input int idx, output int n);
        n = 0;
        while (n < 60 && !done[idx]) begin
            @(negedge clk);
            start = '0;
            n++;
        end
    endtask

    initial begin
        int n;
        int doneSeen;
        compareCnt = 0;
        failCnt    = 0;
        reset      = 1'b1;
        start      = '0;
        op         = SH_SLL;
        dataIn     = '0;
        shamt      = '0;

        // Reset state of every instance.
        #1;
        for (int i = 0; i < NDUT; i++) begin
            checkOutput($sformatf("rst busy s%0d", stepOf(i)), busy[i], 0);
            checkOutput($sformatf("rst done s%0d", stepOf(i)), done[i], 0);
            checkOutput($sformatf("rst result s%0d", stepOf(i)), result[i], 0);
        end
        @(negedge clk);
        reset = 1'b0;

        // SRA of 0x80000000 by 4 with STEP=1.
        applyStimulus(5'b11111, SH_SRA, 32'h8000_0000, 5'd4);
        checkOutput("sra4 s1 value", res[0], 32'hF800_0000);
        checkOutput("sra4 s1 latency", lat[0], 5);

        // SRL of 0xF0000000 by 6 with STEP=4.
        applyStimulus(5'b11111, SH_SRL, 32'hF000_0000, 5'd6);
        checkOutput("srl6 s4 value", res[2], 32'h03C0_0000);
        checkOutput("srl6 s4 latency", lat[2], 3);

        // Rotate and full-width boundary cases.
        applyStimulus(5'b11111, SH_ROR, 32'h0000_0001, 5'd1);
        checkOutput("ror1 value", res[0], 32'h8000_0000);
        applyStimulus(5'b11111, SH_SLL, 32'hFFFF_FFFF, 5'd31);
        checkOutput("sll31 value", res[0], 32'h8000_0000);

        // Zero shift amount on every op.
        for (int o = 0; o < 4; o++) begin
            applyStimulus(5'b11111, 2'(o), 32'hA5C3_1E96, 5'd0);
        end

        // Start pulsed while busy must be ignored.
        @(negedge clk);
        op     = SH_SRL;
        dataIn = 32'h1234_5678;
        shamt  = 5'd8;
        start  = 5'b00001;
        @(negedge clk);
        start = '0;
        @(negedge clk);
        op     = SH_SLL;
        dataIn = 32'hAAAA_AAAA;
        shamt  = 5'd1;
        start  = 5'b00001;
        @(negedge clk);
        start = '0;
        waitDone(0, n);
        checkOutput("ignore result", result[0], 32'h0012_3456);
        checkOutput("ignore latency", 3 + n, 9);
        @(negedge clk);
        checkOutput("ignore not queued busy", busy[0], 0);
        checkOutput("ignore not queued done", done[0], 0);

        // Back-to-back: new request accepted in the DONE cycle.
        @(negedge clk);
        op     = SH_SLL;
        dataIn = 32'h0000_0001;
        shamt  = 5'd3;
        start  = 5'b00001;
        @(negedge clk);
        start = '0;
        waitDone(0, n);
        checkOutput("b2b first result", result[0], 32'h0000_0008);
        op     = SH_SRA;
        dataIn = 32'hFFFF_FF00;
        shamt  = 5'd8;
        start  = 5'b00001;
        @(negedge clk);
        start = '0;
        checkOutput("b2b no bubble busy", busy[0], 1);
        checkOutput("b2b no bubble done", done[0], 0);
        waitDone(0, n);
        checkOutput("b2b second result", result[0], 32'hFFFF_FFFF);
        checkOutput("b2b second latency", 1 + n, 9);

        // Asynchronous reset in the middle of a shift.
        @(negedge clk);
        op     = SH_SLL;
        dataIn = 32'h0000_FFFF;
        shamt  = 5'd20;
        start  = 5'b00001;
        @(negedge clk);
        start = '0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort busy", busy[0], 0);
        checkOutput("abort done", done[0], 0);
        checkOutput("abort result", result[0], 0);
        @(negedge clk);
        reset    = 1'b0;
        doneSeen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done[0]) doneSeen++;
        end
        checkOutput("abort no done pulse", doneSeen, 0);
        applyStimulus(5'b11111, SH_SRA, 32'h9000_0001, 5'd13);

        // Sweep all ops and all shift amounts with random operands.
        for (int o = 0; o < 4; o++) begin
            for (int s = 0; s < 32; s++) begin
                applyStimulus(5'b11111, 2'(o), 32'($urandom), 5'(s));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, failCnt);
        $finish;
    end

endmodule
